// File: rtl/sr_drive_sequencer.sv
// sr_drive_sequencer: synchronizes and debounces set/clear requests and sequences
// non-overlapping, fixed-width s/r pulses into a downstream SR latch.
module sr_drive_sequencer #(
  parameter int unsigned DEB_LEN = 3,
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned GAP_W   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_mon,
  output logic s,
  output logic r,
  output logic busy,
  output logic q_exp,
  output logic conflict,
  output logic mismatch
);

  localparam int unsigned CW  = 4;
  localparam int unsigned NCH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    CLR_P = 2'd2,
    GAP   = 2'd3
  } state_e;

  // Channel 0 carries set requests, channel 1 carries clear requests.
  logic [NCH-1:0] req_c;
  logic [NCH-1:0] sync1_q;
  logic [NCH-1:0] sync2_q;
  logic [NCH-1:0] deb_q;
  logic [NCH-1:0] deb_prev_q;
  logic [NCH-1:0] ev_c;
  logic [CW-1:0]  deb_cnt_q [NCH];

  assign req_c = {clr_req, set_req};

  // 2-flop synchronizer, then a debouncer that flips only after DEB_LEN differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= req_c;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (deb_cnt_q[i] == CW'(DEB_LEN - 1)) begin
            deb_q[i]     <= sync2_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + CW'(1);
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign ev_c = deb_q & ~deb_prev_q;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_set_q, pend_set_d;
  logic          pend_clr_q, pend_clr_d;
  logic          q_exp_q, q_exp_d;
  logic          conflict_q, conflict_d;
  logic          mismatch_q, mismatch_d;
  logic          s_q, s_d;
  logic          r_q, r_d;
  logic          busy_q, busy_d;
  logic          set_any_c, clr_any_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_set_q <= 1'b0;
      pend_clr_q <= 1'b0;
      q_exp_q    <= 1'b0;
      conflict_q <= 1'b0;
      mismatch_q <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_set_q <= pend_set_d;
      pend_clr_q <= pend_clr_d;
      q_exp_q    <= q_exp_d;
      conflict_q <= conflict_d;
      mismatch_q <= mismatch_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_set_d = pend_set_q;
    pend_clr_d = pend_clr_q;
    q_exp_d    = q_exp_q;
    conflict_d = 1'b0;
    mismatch_d = mismatch_q;
    set_any_c  = pend_set_q | ev_c[0];
    clr_any_c  = pend_clr_q | ev_c[1];

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ev_c[0] && ev_c[1]) begin
          conflict_d = 1'b1;
        end else if (ev_c[0]) begin
          state_d = SET_P;
        end else if (ev_c[1]) begin
          state_d = CLR_P;
        end
      end
      SET_P, CLR_P: begin
        pend_set_d = set_any_c;
        pend_clr_d = clr_any_c;
        if (cnt_q == CW'(PULSE_W - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
          q_exp_d = (state_q == SET_P);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_W - 1)) begin
          cnt_d      = '0;
          pend_set_d = 1'b0;
          pend_clr_d = 1'b0;
          if (q_mon != q_exp_q) begin
            mismatch_d = 1'b1;
          end
          // Pending work of both kinds at the hand-off is ambiguous: drop it.
          if (set_any_c && clr_any_c) begin
            conflict_d = 1'b1;
            state_d    = IDLE;
          end else if (set_any_c) begin
            state_d = SET_P;
          end else if (clr_any_c) begin
            state_d = CLR_P;
          end else begin
            state_d = IDLE;
          end
        end else begin
          pend_set_d = set_any_c;
          pend_clr_d = clr_any_c;
          cnt_d      = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (pend_set_d && pend_clr_d) begin
      pend_set_d = 1'b0;
      pend_clr_d = 1'b0;
      conflict_d = 1'b1;
    end

    s_d    = (state_d == SET_P);
    r_d    = (state_d == CLR_P);
    busy_d = (state_d != IDLE);
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign q_exp    = q_exp_q;
  assign conflict = conflict_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Bench for sr_drive_sequencer: directed scenarios plus random request levels, all
// compared each cycle against a timeline/command-level reference model.
module tb_sr_drive_sequencer;

  localparam int unsigned DEB_LEN = 3;
  localparam int unsigned PULSE_W = 4;
  localparam int unsigned GAP_W   = 2;
  localparam int          MAXE    = 4096;

  logic clk = 1'b0;
  logic rst_n;
  logic set_req, clr_req, q_mon;
  logic s, r, busy, q_exp, conflict, mismatch;
  logic [5:0] got_v;

  int n_cmp = 0;
  int n_fail = 0;

  sr_drive_sequencer #(.DEB_LEN(DEB_LEN), .PULSE_W(PULSE_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .clr_req(clr_req), .q_mon(q_mon),
    .s(s), .r(r), .busy(busy), .q_exp(q_exp), .conflict(conflict), .mismatch(mismatch)
  );

  always #5 clk = ~clk;
  assign got_v = {s, r, busy, q_exp, conflict, mismatch};

  // Reference model: raw sample history per channel, debounced level derived from a
  // sliding window, and commands tracked by start/end edge numbers.
  bit   hraw [2][MAXE];
  bit   hdeb [2][MAXE];
  int   m_k, m_t0, m_end;
  bit   m_busy, m_is_set, pend_s, pend_c, qexp_m, mis_m, conf_m;
  logic [5:0] exp_v;
  int   qm_mode;
  bit   latch_q;

  function automatic bit raw_at(input int ch, input int j);
    return (j < 1) ? 1'b0 : hraw[ch][j];
  endfunction

  function automatic bit deb_at(input int ch, input int j);
    return (j < 1) ? 1'b0 : hdeb[ch][j];
  endfunction

  task automatic model_reset();
    m_k = 0; m_busy = 0; m_is_set = 0; pend_s = 0; pend_c = 0;
    qexp_m = 0; mis_m = 0; conf_m = 0; m_t0 = 0; m_end = 0;
    exp_v = '0;
  endtask

  task automatic model_start(input bit is_set);
    m_busy = 1; m_is_set = is_set; m_t0 = m_k; m_end = m_k + int'(PULSE_W + GAP_W);
  endtask

  task automatic model_step(input bit rs, input bit rc, input bit qm);
    bit se, ce, all1, all0, v, ps;
    m_k++;
    if (m_k >= MAXE) begin
      $display("FAIL model_capacity edge %0d exceeds history %0d", m_k, MAXE);
      $fatal(1);
    end
    hraw[0][m_k] = rs;
    hraw[1][m_k] = rc;
    for (int ch = 0; ch < 2; ch++) begin
      all1 = 1; all0 = 1;
      for (int i = 0; i < int'(DEB_LEN); i++) begin
        v = raw_at(ch, m_k - 2 - i);
        if (v) all0 = 0; else all1 = 0;
      end
      hdeb[ch][m_k] = all1 ? 1'b1 : (all0 ? 1'b0 : deb_at(ch, m_k - 1));
    end
    se = deb_at(0, m_k - 1) && !deb_at(0, m_k - 2);
    ce = deb_at(1, m_k - 1) && !deb_at(1, m_k - 2);
    conf_m = 0;
    if (m_busy && m_k == m_t0 + int'(PULSE_W)) qexp_m = m_is_set;
    if (m_busy && m_k < m_end) begin
      pend_s |= se; pend_c |= ce;
      if (pend_s && pend_c) begin pend_s = 0; pend_c = 0; conf_m = 1; end
    end else if (m_busy) begin
      if (qm != qexp_m) mis_m = 1;
      pend_s |= se; pend_c |= ce; m_busy = 0;
      if (pend_s && pend_c) begin
        pend_s = 0; pend_c = 0; conf_m = 1;
      end else if (pend_s) begin
        pend_s = 0; model_start(1);
      end else if (pend_c) begin
        pend_c = 0; model_start(0);
      end
    end else begin
      if (se && ce) conf_m = 1;
      else if (se) model_start(1);
      else if (ce) model_start(0);
    end
    ps = m_busy && (m_k < m_t0 + int'(PULSE_W));
    exp_v = {ps && m_is_set, ps && !m_is_set, m_busy, qexp_m, conf_m, mis_m};
  endtask

  // Drive one cycle of request levels; q_mon models the latch (or is forced/random).
  task automatic step(input bit sr, input bit cr);
    bit qm;
    case (qm_mode)
      0:       qm = latch_q;
      1:       qm = 1'b0;
      default: qm = 1'($urandom_range(0, 1));
    endcase
    set_req = sr; clr_req = cr; q_mon = qm;
    @(posedge clk);
    #1;
    model_step(sr, cr, qm);
    if (s) latch_q = 1'b1;
    else if (r) latch_q = 1'b0;
  endtask

  task automatic do_reset(input bit hold_set);
    rst_n = 1'b0; set_req = hold_set; clr_req = 1'b0; q_mon = 1'b0; latch_q = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; set_req = 0; clr_req = 0; q_mon = 0; latch_q = 0; qm_mode = 0;
    #1 rst_n = 1'b0;
    #3;
    n_cmp++;
    if (got_v !== 6'b0) begin
      n_fail++; $display("FAIL reset_values: got %b required %b", got_v, 6'b0);
    end
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(0, 0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL reset_idle edge %0d: got %b expected %b", m_k, got_v, exp_v);
      end
    end
  endtask

  task automatic test_set_latency();
    bit es, eb, eq;
    do_reset(0); qm_mode = 0;
    for (int c = 1; c <= 14; c++) begin
      step(1, 0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL set_latency_model edge %0d: got %b expected %b", m_k, got_v, exp_v);
      end
      es = (c >= 6 && c <= 9); eb = (c >= 6 && c <= 11); eq = (c >= 10);
      n_cmp++;
      if ({s, busy, q_exp} !== {es, eb, eq}) begin
        n_fail++; $display("FAIL set_latency_timing cycle %0d: s/busy/q_exp=%b required %b", c, {s, busy, q_exp}, {es, eb, eq});
      end
    end
    n_cmp++;
    if (mismatch !== 1'b0) begin
      n_fail++; $display("FAIL set_latency_mismatch: got %b required 0", mismatch);
    end
    for (int c = 0; c < 8; c++) begin
      step(0, 0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL set_release edge %0d: got %b expected %b", m_k, got_v, exp_v);
      end
    end
  endtask

  task automatic test_conflict();
    int conf_cnt, sr_cnt;
    conf_cnt = 0; sr_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      step(1, 1);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL conflict_model edge %0d: got %b expected %b", m_k, got_v, exp_v);
      end
      if (conflict) conf_cnt++;
      if (s || r) sr_cnt++;
    end
    n_cmp++;
    if (conf_cnt !== 1 || sr_cnt !== 0 || q_exp !== 1'b1) begin
      n_fail++; $display("FAIL conflict_pulse: pulses=%0d sr_cycles=%0d q_exp=%b required 1/0/1", conf_cnt, sr_cnt, q_exp);
    end
    for (int c = 0; c < 8; c++) begin
      step(0, 0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL conflict_release edge %0d: got %b expected %b", m_k, got_v, exp_v);
      end
    end
  endtask

  task automatic test_glitch();
    int s_cnt;
    s_cnt = 0;
    do_reset(0); qm_mode = 0;
    for (int c = 0; c < 16; c++) begin
      step(c < 2, 0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL glitch_model edge %0d: got %b expected %b", m_k, got_v, exp_v);
      end
      if (s || busy) s_cnt++;
    end
    n_cmp++;
    if (s_cnt !== 0) begin
      n_fail++; $display("FAIL glitch_filtered: active cycles=%0d required 0", s_cnt);
    end
  endtask

  task automatic test_clr_during_set();
    int s_cnt, r_cnt, last_s, first_r;
    s_cnt = 0; r_cnt = 0; last_s = -1; first_r = -1;
    do_reset(0); qm_mode = 0;
    for (int c = 1; c <= 30; c++) begin
      step(c <= 10, c >= 2 && c <= 12);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL clr_during_set_model edge %0d: got %b expected %b", m_k, got_v, exp_v);
      end
      n_cmp++;
      if (s && r) begin
        n_fail++; $display("FAIL overlap cycle %0d: s=%b r=%b required not both", c, s, r);
      end
      if (s) begin s_cnt++; last_s = c; end
      if (r) begin r_cnt++; if (first_r < 0) first_r = c; end
    end
    n_cmp++;
    if (s_cnt !== 4 || r_cnt !== 4 || (first_r - last_s) !== 3 || q_exp !== 1'b0) begin
      n_fail++; $display("FAIL clr_after_set: s=%0d r=%0d gap_span=%0d q_exp=%b required 4/4/3/0", s_cnt, r_cnt, first_r - last_s, q_exp);
    end
  endtask

  task automatic test_pending_conflict();
    int conf_cnt, s_cnt, r_cnt;
    conf_cnt = 0; s_cnt = 0; r_cnt = 0;
    do_reset(0); qm_mode = 0;
    for (int i = 0; i < 30; i++) begin
      step((i < 3) || (i >= 6 && i < 12), i >= 2 && i < 8);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL pending_conflict_model edge %0d: got %b expected %b", m_k, got_v, exp_v);
      end
      if (conflict) conf_cnt++;
      if (s) s_cnt++;
      if (r) r_cnt++;
    end
    n_cmp++;
    if (conf_cnt !== 1 || s_cnt !== 4 || r_cnt !== 0) begin
      n_fail++; $display("FAIL pending_conflict: conflicts=%0d s=%0d r=%0d required 1/4/0", conf_cnt, s_cnt, r_cnt);
    end
  endtask

  task automatic test_mismatch();
    do_reset(0); qm_mode = 1;
    for (int c = 0; c < 16; c++) begin
      step(c < 10, 0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL mismatch_model edge %0d: got %b expected %b", m_k, got_v, exp_v);
      end
    end
    n_cmp++;
    if (mismatch !== 1'b1) begin
      n_fail++; $display("FAIL mismatch_set: got %b required 1", mismatch);
    end
    qm_mode = 0;
    for (int c = 0; c < 40; c++) begin
      step(c >= 20 && c < 30, c < 10);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL mismatch_sticky_model edge %0d: got %b expected %b", m_k, got_v, exp_v);
      end
    end
    n_cmp++;
    if (mismatch !== 1'b1 || q_exp !== 1'b1) begin
      n_fail++; $display("FAIL mismatch_sticky: mismatch=%b q_exp=%b required 1/1", mismatch, q_exp);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int act;
    act = 0;
    do_reset(0); qm_mode = 0;
    for (int c = 0; c < 7; c++) begin
      step(1, 0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL mid_pulse_model edge %0d: got %b expected %b", m_k, got_v, exp_v);
      end
    end
    set_req = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (got_v !== 6'b0) begin
      n_fail++; $display("FAIL async_reset: got %b required %b", got_v, 6'b0);
    end
    repeat (2) @(negedge clk);
    model_reset();
    latch_q = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(0, 0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL post_reset_model edge %0d: got %b expected %b", m_k, got_v, exp_v);
      end
      if (s || r || busy) act++;
    end
    n_cmp++;
    if (act !== 0) begin
      n_fail++; $display("FAIL post_reset_quiet: active cycles=%0d required 0", act);
    end
  endtask

  task automatic test_reset_held();
    do_reset(1); qm_mode = 0;
    for (int c = 1; c <= 12; c++) begin
      step(1, 0);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL held_model edge %0d: got %b expected %b", m_k, got_v, exp_v);
      end
      n_cmp++;
      if (s !== (c >= 6 && c <= 9)) begin
        n_fail++; $display("FAIL held_after_reset cycle %0d: s=%b required %b", c, s, (c >= 6 && c <= 9));
      end
    end
  endtask

  task automatic test_random();
    int hs_left, hc_left;
    bit ls, lc;
    hs_left = 0; hc_left = 0; ls = 0; lc = 0;
    do_reset(0); qm_mode = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 250 == 0) qm_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      if (hs_left == 0) begin ls = 1'($urandom_range(0, 1)); hs_left = int'($urandom_range(1, 10)); end
      if (hc_left == 0) begin lc = 1'($urandom_range(0, 1)); hc_left = int'($urandom_range(1, 10)); end
      hs_left--; hc_left--;
      step(ls, lc);
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++; $display("FAIL random edge %0d: got %b expected %b", m_k, got_v, exp_v);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_set_latency();
    test_conflict();
    test_glitch();
    test_clr_during_set();
    test_pending_conflict();
    test_mismatch();
    test_reset_mid_pulse();
    test_reset_held();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_drive_sequencer.md
SR_DRIVE_SEQUENCER -- requirements
Module: sr_drive_sequencer

Interface
REQ-001 SHALL have parameter DEB_LEN, default 3, meaning consecutive stable synchronized samples needed to accept a request level change (range 1..15).
REQ-002 SHALL have parameter PULSE_W, default 4, meaning cycles s or r is held high per command (range 1..15).
REQ-003 SHALL have parameter GAP_W, default 2, meaning cycles s and r are both held low after each pulse before a new pulse (range 1..15).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port set_req  input  1  asynchronous set request level from switch/external logic.
REQ-007 SHALL have port clr_req  input  1  asynchronous clear request level.
REQ-008 SHALL have port q_mon  input  1  q fed back from the downstream sr_latch.
REQ-009 SHALL have port s  output  1  set drive to sr_latch, registered.
REQ-010 SHALL have port r  output  1  reset drive to sr_latch, registered.
REQ-011 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-012 SHALL have port q_exp  output  1  expected latch state after the last completed command.
REQ-013 SHALL have port conflict  output  1  one-cycle pulse when set and clear events coincide and are dropped.
REQ-014 SHALL have port mismatch  output  1  sticky flag, q_mon differed from q_exp at a check point.

Function
REQ-015 SHALL pass set_req and clr_req each through a 2-flop synchronizer, then a debouncer whose accepted level changes only after DEB_LEN consecutive edges of the synchronized value differing from it.
REQ-016 SHALL generate a set event (clear event) on a rising edge of the debounced set (clear) level; falling edges generate nothing.
REQ-017 SHALL implement FSM states IDLE, SET_P, CLR_P, GAP.
REQ-018 IDLE: set event only -> SET_P; clear event only -> CLR_P; both in same cycle -> stay IDLE, pulse conflict, no command.
REQ-019 SET_P: s=1, r=0 for exactly PULSE_W cycles, then -> GAP with q_exp<=1.
REQ-020 CLR_P: r=1, s=0 for exactly PULSE_W cycles, then -> GAP with q_exp<=0.
REQ-021 GAP: s=r=0 for exactly GAP_W cycles, then -> IDLE (or directly to SET_P/CLR_P if a pending event is held).
REQ-022 SHALL never drive s=1 and r=1 in the same cycle, in any state, including across reset.
REQ-023 Events arriving while busy SHALL be held in one pending slot per type; if both slots fill before leaving GAP, both SHALL be dropped and conflict pulsed once.
REQ-024 A repeated event of the same type while already pending SHALL be absorbed (no second command).
REQ-025 Commands SHALL be issued even if redundant (set while q_exp=1).
REQ-026 On the last GAP cycle, SHALL compare q_mon to q_exp; if unequal, set mismatch=1; mismatch stays 1 until reset.
REQ-027 Latency with DEB_LEN=3: s or r SHALL be high after the 6th rising clk edge counted from the first edge sampling a stable request high.
REQ-028 busy SHALL rise with s/r and fall on the first IDLE cycle.

Reset
REQ-029 rst_n low SHALL immediately force s=0, r=0, busy=0, q_exp=0, conflict=0, mismatch=0, FSM=IDLE, pending slots cleared, synchronizer and debounced levels 0.
REQ-030 Reset asserted mid-pulse SHALL drop s/r in the same instant, without waiting for clk; no command SHALL resume after release.
REQ-031 After rst_n release, a request already held high SHALL be treated as a new rising event after sync+debounce delay.

Verification
REQ-032 Defaults, set_req 0->1 held, q_mon follows -> s high cycles 6..9, GAP 10..11, q_exp=1, busy low at 12, mismatch 0.
REQ-033 set_req and clr_req rise on same clk edge -> conflict one-cycle pulse, s and r stay 0, q_exp unchanged.
REQ-034 set_req glitch high for 2 cycles (< DEB_LEN after sync) -> no event, s stays 0.
REQ-035 clr event during SET_P -> SET pulse completes, GAP of 2 cycles, then r high 4 cycles, q_exp=0; s&r never both 1.
REQ-036 set command with q_mon held 0 -> mismatch=1 after GAP and stays 1 through later successful commands.
REQ-037 rst_n low in cycle 2 of SET_P -> s=0 asynchronously, all outputs at reset values, no pulse after release while requests low.
